// File: rtl/sugar_placer_pkg.sv
// Shared types and constants for the sugar placement engine.
package sugar_placer_pkg;

  // Screen coordinate widths.
  localparam int X_bits = 10;
  localparam int Y_bits = 9;

  // Feedback taps of the 16-bit Galois LFSR that produces candidate positions.
  localparam logic [15:0] PLACER_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN_X = 3'd1,
    ST_GEN_Y = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } placer_state_t;

  // One Galois shift: drop the low bit and fold the taps in when it was set.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? PLACER_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sugar_placer_collision_square.sv
// Square-box collision test: a hit when the check point lies strictly inside
// the box of half-width radius centred on the object, on both axes at once.
module collision_square
  import sugar_placer_pkg::*;
(
  input  logic [X_bits-1:0] check_x,
  input  logic [Y_bits-1:0] check_y,
  input  logic [X_bits-1:0] obj_x,
  input  logic [Y_bits-1:0] obj_y,
  input  logic [X_bits-1:0] radius,
  output logic              hit
);

  // Common width so the y distance can be compared against an x-wide radius.
  localparam int CW = (X_bits > Y_bits) ? X_bits : Y_bits;

  logic [X_bits-1:0] dx;
  logic [Y_bits-1:0] dy;

  // Absolute distance per axis, then the strict inside-the-box test.
  always_comb begin
    dx  = (check_x >= obj_x) ? (check_x - obj_x) : (obj_x - check_x);
    dy  = (check_y >= obj_y) ? (check_y - obj_y) : (obj_y - check_y);
    hit = (CW'(dx) < CW'(radius)) && (CW'(dy) < CW'(radius));
  end

endmodule

// File: rtl/sugar_placer.sv
// Sugar placement engine: draws pseudo-random candidates and scans the world
// object table one entry per cycle until a clear spot or the try budget ends.
module sugar_placer
  import sugar_placer_pkg::*;
#(
  parameter int          NUM_OBJ      = 16,
  parameter int          CLEAR_RADIUS = 24,
  parameter int          X_MAX        = 640,
  parameter int          Y_MAX        = 480,
  parameter int          MAX_TRIES    = 32,
  parameter logic [15:0] SEED         = 16'hACE1,
  localparam int         CW           = $clog2(NUM_OBJ + 1),
  localparam int         IW           = $clog2(NUM_OBJ)
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [CW-1:0]     obj_count,
  output logic [IW-1:0]     obj_idx,
  input  logic [X_bits-1:0] obj_x,
  input  logic [Y_bits-1:0] obj_y,
  output logic              busy,
  output logic              place_valid,
  output logic              place_fail,
  output logic [X_bits-1:0] place_x,
  output logic [Y_bits-1:0] place_y
);

  localparam int          TW       = $clog2(MAX_TRIES + 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [31:0] X_LIM    = 32'(X_MAX);
  localparam logic [31:0] Y_LIM    = 32'(Y_MAX);

  placer_state_t     state;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [X_bits-1:0] cand_x;
  logic [Y_bits-1:0] cand_y;
  logic [CW-1:0]     count_hold;
  logic [TW-1:0]     tries;
  logic [TW-1:0]     tries_inc;
  logic              success;
  logic              hit;
  logic              out_of_bounds;
  logic              reject;
  logic              last_obj;

  collision_square u_collision (
    .check_x (cand_x),
    .check_y (cand_y),
    .obj_x   (obj_x),
    .obj_y   (obj_y),
    .radius  (X_bits'(CLEAR_RADIUS)),
    .hit     (hit)
  );

  // Per-cycle scan decisions. Bounds are re-tested every SCAN cycle, which only
  // ever matters on the first one: an out-of-range candidate is rejected there.
  always_comb begin
    lfsr_next     = lfsr_step(lfsr);
    out_of_bounds = (32'(cand_x) >= X_LIM) || (32'(cand_y) >= Y_LIM);
    reject        = hit || out_of_bounds;
    tries_inc     = tries + TW'(1);
    last_obj      = (CW'(obj_idx) == (count_hold - CW'(1)));
  end

  // Result pulses come straight from the DONE state, so they are exclusive.
  always_comb begin
    busy        = (state != ST_IDLE);
    place_valid = (state == ST_DONE) && success;
    place_fail  = (state == ST_DONE) && !success;
  end

  // Placement sequencer. place_x/y are loaded on entry to DONE so the accepted
  // coordinate is already visible alongside the place_valid pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      lfsr       <= SEED_EFF;
      cand_x     <= '0;
      cand_y     <= '0;
      count_hold <= '0;
      obj_idx    <= '0;
      tries      <= '0;
      success    <= 1'b0;
      place_x    <= '0;
      place_y    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count_hold <= obj_count;
            tries      <= '0;
            state      <= ST_GEN_X;
          end
        end
        ST_GEN_X: begin
          cand_x <= lfsr_next[X_bits-1:0];
          lfsr   <= lfsr_next;
          state  <= ST_GEN_Y;
        end
        ST_GEN_Y: begin
          cand_y  <= lfsr_next[Y_bits-1:0];
          lfsr    <= lfsr_next;
          obj_idx <= '0;
          if (count_hold == '0) begin
            // Empty table: nothing to collide with, accept as drawn.
            success <= 1'b1;
            place_x <= cand_x;
            place_y <= lfsr_next[Y_bits-1:0];
            state   <= ST_DONE;
          end else begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (reject) begin
            tries   <= tries_inc;
            obj_idx <= '0;
            if (tries_inc == TW'(MAX_TRIES)) begin
              success <= 1'b0;
              state   <= ST_DONE;
            end else begin
              state <= ST_GEN_X;
            end
          end else if (last_obj) begin
            success <= 1'b1;
            place_x <= cand_x;
            place_y <= cand_y;
            obj_idx <= '0;
            state   <= ST_DONE;
          end else begin
            obj_idx <= obj_idx + IW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
